iterative_shifter: RTL and testbench

- Parametrised multi-cycle shift unit for the RV32 execute stage.
- Performs SLL, SRL, SRA and ROR on an XLEN-bit operand by a variable shift amount.
- Shifts at most STEP bit positions per clock, trading latency for a small, short-path datapath.
- Valid/ready handshakes on both sides; a pipeline-squash flush input.

---
 rtl/shifter_pkg.sv | 15 +
 rtl/shift_step_unit.sv | 39 +++
 rtl/iterative_shifter.sv | 101 ++++++++++
 tb/tb_iterative_shifter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - op encodings and FSM state type for the iterative shifter
package shifter_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;

endpackage

// File: rtl/shift_step_unit.sv
// rtl/shift_step_unit.sv - combinational shift/rotate of data by k in 0..STEP
module shift_step_unit
    import shifter_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 4,
    parameter int KW   = $clog2(STEP) + 1
) (
    input  logic [XLEN-1:0] data,
    input  logic [1:0]      op,
    input  logic [KW-1:0]   k,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] stage [0:KW];

    assign stage[0] = data;

    // Stage i moves the value by 2**i when bit i of k is set.
    for (genvar i = 0; i < KW; i++) begin : g_stage
        localparam int AMT = 1 << i;
        logic [XLEN-1:0] moved;

        always_comb begin
            moved = stage[i];
            case (op)
                OP_SLL:  moved = stage[i] << AMT;
                OP_SRL:  moved = stage[i] >> AMT;
                OP_SRA:  moved = XLEN'($signed(stage[i]) >>> AMT);
                default: moved = (stage[i] >> AMT) | (stage[i] << (XLEN - AMT));
            endcase
        end

        assign stage[i+1] = k[i] ? moved : stage[i];
    end

    assign result = stage[KW];

endmodule

// File: rtl/iterative_shifter.sv
// rtl/iterative_shifter.sv - multi-cycle SLL/SRL/SRA/ROR unit, at most STEP bits per clock
module iterative_shifter
    import shifter_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = $clog2(XLEN),
    parameter int STEP    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [XLEN-1:0]    operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    result,
    output logic               busy
);

    localparam int KW = $clog2(STEP) + 1;

    shift_state_t       state_q, state_d;
    logic [XLEN-1:0]    data_q, data_d;
    logic [1:0]         op_q, op_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [KW-1:0]      k;
    logic [XLEN-1:0]    step_out;
    logic [SHAMT_W-1:0] rem_next;

    assign k        = (rem_q < SHAMT_W'(STEP)) ? KW'(rem_q) : KW'(STEP);
    assign rem_next = rem_q - SHAMT_W'(k);

    shift_step_unit #(
        .XLEN (XLEN),
        .STEP (STEP),
        .KW   (KW)
    ) u_step (
        .data   (data_q),
        .op     (op_q),
        .k      (k),
        .result (step_out)
    );

    assign in_ready  = (state_q == IDLE) & ~rst & ~flush;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = data_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        op_d    = op_q;
        rem_d   = rem_q;
        // flush abandons the operation but leaves data_q as it was
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        data_d  = operand;
                        op_d    = op;
                        rem_d   = shamt;
                        state_d = (shamt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    data_d = step_out;
                    rem_d  = rem_next;
                    if (rem_next == '0) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            op_q    <= OP_SLL;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_iterative_shifter.sv
// tb/tb_iterative_shifter.sv - self-checking bench for iterative_shifter
module tb_iterative_shifter;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;
    localparam int STEP    = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         op;
    logic [XLEN-1:0]    operand;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    result;
    logic               busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    iterative_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W),
        .STEP    (STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand   (operand),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Reference: whole-amount arithmetic; rotation done one bit at a time.
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] v, input int n);
        logic [31:0] r;
        case (o)
            2'b00:   r = v << n;
            2'b01:   r = v >> n;
            2'b10:   r = 32'($signed(v) >>> n);
            default: begin
                r = v;
                for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
            end
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input int n);
        return 1 + (n + STEP - 1) / STEP;
    endfunction

    task automatic issue(input string tag, input logic [1:0] o, input logic [31:0] v, input int n);
        op       = o;
        operand  = v;
        shamt    = SHAMT_W'(n);
        in_valid = 1'b1;
        #1;
        chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] v,
                          input int n, input logic [31:0] exp, input int hold);
        int lat;
        issue(tag, o, v, n);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(ref_lat(n)));
        chk({tag, "_result"}, result, exp);
        chk({tag, "_done_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_done_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            operand  = ~v;
            shamt    = '0;
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_result"}, result, exp);
            chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drain_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_drain_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic abort_case(input bit use_rst);
        logic [31:0] v;
        int seen;
        v = $urandom | 32'h1;
        issue(use_rst ? "rst_abort" : "flush_abort", 2'b00, v, 20);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("abort_partial", result, ref_shift(2'b00, v, 8));
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        in_valid = 1'b1;
        op       = 2'b01;
        operand  = 32'h0000_00FF;
        shamt    = '0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_result", result, use_rst ? 32'h0 : ref_shift(2'b00, v, 8));
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        run_op("after_abort", 2'b01, 32'h0000_00FF, 4, 32'h0000_000F, 0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] rv;
        int          rn;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; operand = '0; shamt = '0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_result", result, 32'h0);
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);

        run_op("sll31", 2'b00, 32'h0000_0001, 31, 32'h8000_0000, 0);
        run_op("sra4", 2'b10, 32'h8000_0000, 4, 32'hF800_0000, 0);
        run_op("srl4", 2'b01, 32'h8000_0000, 4, 32'h0800_0000, 0);
        run_op("ror1", 2'b11, 32'h0000_0001, 1, 32'h8000_0000, 0);
        run_op("ror8", 2'b11, 32'h1234_5678, 8, 32'h7812_3456, 0);
        for (int o = 0; o < 4; o++) begin
            run_op("zero_amt", 2'(o), 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1);
        end
        run_op("backpressure", 2'b01, 32'hF0F0_F0F0, 7, 32'h01E1_E1E1, 5);

        abort_case(1'b0);
        abort_case(1'b1);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            rv = $urandom;
            rn = int'($urandom_range(0, 31));
            run_op("random", ro, rv, rn, ref_shift(ro, rv, rn), i % 3);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
